// File: rtl/edge_event_arbiter.sv
// Rising-edge capture into per-channel pending flags, served one at a time
// over valid/ready with round-robin fairness. Optional lost-event flags: EDGE_EVT_OVERFLOW_EN.
module edge_event_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    sig,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  input  logic            evt_ready,
  output logic [N-1:0]    pending
`ifdef EDGE_EVT_OVERFLOW_EN
  ,
  output logic [N-1:0]    overflow,
  input  logic [N-1:0]    ovf_clr
`endif
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [N-1:0]      sig_dly_reg;
  logic [N-1:0]      pending_reg;
  logic [N-1:0]      edge_det;
  logic [N-1:0]      clr;
  logic [ID_W-1:0]   evt_id_reg;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic [ID_W-1:0]   sel_id;
  logic              accept;

  assign accept = (state_reg == OFFER) && evt_ready;

  always_ff @(posedge clk) begin
    sig_dly_reg <= sig;
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      assign edge_det[gi] = sig[gi] & ~sig_dly_reg[gi];
      assign clr[gi]      = accept && (evt_id_reg == ID_W'(gi));

      // A fresh edge in the accept cycle re-arms the channel.
      always_ff @(posedge clk) begin
        if (rst) begin
          pending_reg[gi] <= 1'b0;
        end else begin
          pending_reg[gi] <= (pending_reg[gi] & ~clr[gi]) | edge_det[gi];
        end
      end

`ifdef EDGE_EVT_OVERFLOW_EN
      logic ovf_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_reg <= 1'b0;
        end else if (edge_det[gi] & pending_reg[gi] & ~clr[gi]) begin
          ovf_reg <= 1'b1;
        end else if (ovf_clr[gi]) begin
          ovf_reg <= 1'b0;
        end
      end
      assign overflow[gi] = ovf_reg;
`endif
    end
  endgenerate

  // Round-robin scan starting at rr_ptr, wrapping at N-1 -> 0.
  always_comb begin
    int  idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    sel_id = '0;
    for (int j = 0; j < N; j++) begin
      idx = int'(rr_ptr_reg) + j;
      if (idx >= N) idx = idx - N;
      if (!found && pending_reg[idx]) begin
        found  = 1'b1;
        sel_id = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pending_reg != '0) state_next = OFFER;
      OFFER:   if (evt_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    evt_valid = (state_reg == OFFER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_id_reg <= '0;
      rr_ptr_reg <= '0;
    end else begin
      if (state_reg == IDLE && pending_reg != '0) begin
        evt_id_reg <= sel_id;
      end
      if (accept) begin
        rr_ptr_reg <= (evt_id_reg == ID_W'(N - 1)) ? '0 : evt_id_reg + 1'b1;
      end
    end
  end

  assign evt_id  = evt_id_reg;
  assign pending = pending_reg;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter (N=4); overflow steps run only
// when EDGE_EVT_OVERFLOW_EN is defined.
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sig;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_ready;
  logic [3:0] pending;
`ifdef EDGE_EVT_OVERFLOW_EN
  logic [3:0] overflow;
  logic [3:0] ovf_clr;
`endif

  int checks   = 0;
  int failures = 0;

  edge_event_arbiter #(.N(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig       (sig),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_ready (evt_ready),
    .pending   (pending)
`ifdef EDGE_EVT_OVERFLOW_EN
    ,
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    logic [1:0] rr_ids [3];
    rr_ids[0] = 2'd0; rr_ids[1] = 2'd1; rr_ids[2] = 2'd3;

    rst = 1'b1; sig = 4'b0000; evt_ready = 1'b0;
`ifdef EDGE_EVT_OVERFLOW_EN
    ovf_clr = 4'b0000;
`endif
    tick(); tick();
    chk("reset_valid", 32'(evt_valid), 32'd0);
    chk("reset_id", 32'(evt_id), 32'd0);
    chk("reset_pending", 32'(pending), 32'd0);
    rst = 1'b0;
    tick();

    // Single edge on ch2
    evt_ready = 1'b1; sig = 4'b0100;
    tick();
    chk("single_pend_k", 32'(pending), 32'h4);
    chk("single_valid_k", 32'(evt_valid), 32'd0);
    tick();
    chk("single_valid_k1", 32'(evt_valid), 32'd1);
    chk("single_id_k1", 32'(evt_id), 32'd2);
    tick();
    chk("single_valid_k2", 32'(evt_valid), 32'd0);
    chk("single_pend_k2", 32'(pending), 32'd0);

    // Round-robin from a fresh rr_ptr
    sig = 4'b0000; rst = 1'b1; tick(); rst = 1'b0; tick();
    sig = 4'b1011;
    tick();
    chk("rr_pend", 32'(pending), 32'hB);
    for (int g = 0; g < 3; g++) begin
      tick();
      chk("rr_valid", 32'(evt_valid), 32'd1);
      chk("rr_id", 32'(evt_id), 32'(rr_ids[g]));
      tick();
      chk("rr_gap", 32'(evt_valid), 32'd0);
    end
    chk("rr_pend_done", 32'(pending), 32'd0);
    sig = 4'b0000; tick();
    sig = 4'b1001;
    tick();
    chk("rr2_pend", 32'(pending), 32'h9);
    tick();
    chk("rr2_id0", 32'(evt_id), 32'd0);
    tick(); tick();
    chk("rr2_valid3", 32'(evt_valid), 32'd1);
    chk("rr2_id3", 32'(evt_id), 32'd3);
    tick();
    chk("rr2_pend_done", 32'(pending), 32'd0);

    // Backpressure: ch1 held while ch0 rises
    sig = 4'b0000; evt_ready = 1'b0; tick();
    sig = 4'b0010;
    tick();
    tick();
    chk("bp_offer_id", 32'(evt_id), 32'd1);
    sig = 4'b0011;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_hold_valid", 32'(evt_valid), 32'd1);
      chk("bp_hold_id", 32'(evt_id), 32'd1);
    end
    chk("bp_pend", 32'(pending), 32'h3);
    evt_ready = 1'b1;
    tick();
    chk("bp_accept_pend", 32'(pending), 32'h1);
    tick();
    chk("bp_ch0_valid", 32'(evt_valid), 32'd1);
    chk("bp_ch0_id", 32'(evt_id), 32'd0);
    tick();
    chk("bp_done_pend", 32'(pending), 32'd0);

    // Same-cycle re-edge on ch1
    sig = 4'b0000; evt_ready = 1'b0; tick();
    sig = 4'b0010; tick(); tick();
    chk("reedge_offer", 32'(evt_id), 32'd1);
    sig = 4'b0000; tick();
    sig = 4'b0010; evt_ready = 1'b1;
    tick();
    chk("reedge_pend", 32'(pending), 32'h2);
    chk("reedge_idle", 32'(evt_valid), 32'd0);
    tick();
    chk("reedge_valid", 32'(evt_valid), 32'd1);
    chk("reedge_id", 32'(evt_id), 32'd1);
    tick();
    chk("reedge_done", 32'(pending), 32'd0);

    // Levels held high across reset release
    sig = 4'b1111; rst = 1'b1; tick(); tick();
    rst = 1'b0; tick(); tick(); tick();
    chk("rst_held_pend", 32'(pending), 32'd0);
    chk("rst_held_valid", 32'(evt_valid), 32'd0);

    // Reset while offering
    sig = 4'b0000; tick();
    sig = 4'b0100; evt_ready = 1'b0; tick(); tick();
    chk("rst_offer_valid", 32'(evt_valid), 32'd1);
    chk("rst_offer_id", 32'(evt_id), 32'd2);
    rst = 1'b1; tick();
    chk("rst_mid_valid", 32'(evt_valid), 32'd0);
    chk("rst_mid_pend", 32'(pending), 32'd0);
    rst = 1'b0; tick();
    chk("rst_after_pend", 32'(pending), 32'd0);
    chk("rst_after_valid", 32'(evt_valid), 32'd0);

`ifdef EDGE_EVT_OVERFLOW_EN
    sig = 4'b0000; tick();
    chk("ovf_init", 32'(overflow), 32'd0);
    sig = 4'b0100; tick();
    sig = 4'b0000; tick();
    sig = 4'b0100; tick();
    chk("ovf_set", 32'(overflow), 32'h4);
    evt_ready = 1'b1; tick();
    chk("ovf_accept_pend", 32'(pending), 32'd0);
    tick();
    chk("ovf_one_event", 32'(evt_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'h4);
    ovf_clr = 4'b0100; tick();
    ovf_clr = 4'b0000;
    chk("ovf_clr", 32'(overflow), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Captures rising edges on N asynchronous-origin, already-synchronised level inputs (buttons, strobes, status lines) into per-channel pending flags.
- Serves pending events one at a time to a single consumer over a valid/ready handshake, with round-robin fairness.
- Sits between the board-level input synchronisers and the control FSM or MCU register block that acts on events.

Parameters:
- N, 4, number of input channels (2..16).
- ID_W, 2, width of evt_id; must satisfy 2^ID_W >= N.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- sig  in  N  level inputs, already synchronised to clk.
- evt_valid  out  1  event offered to consumer.
- evt_id  out  ID_W  channel index of the offered event.
- evt_ready  in  1  consumer accepts the offered event.
- pending  out  N  current pending flags, for status readback.
- overflow  out  N  sticky lost-event flags; present only with EDGE_EVT_OVERFLOW_EN.
- ovf_clr  in  N  per-bit overflow clear; present only with EDGE_EVT_OVERFLOW_EN.

Behaviour:
- Edge detect:
  - sig_dly[N] is a register.
  - edge[i] = sig[i] & ~sig_dly[i].
  - During rst, sig_dly <= sig. A channel held high across reset release therefore produces no event.
- Reset values: pending=0, evt_valid=0, evt_id=0, rr_ptr=0, state=IDLE, overflow=0.
- Capture: pending[i] <= (pending[i] & ~clr[i]) | edge[i].
  - clr[i] is 1 when state=OFFER, evt_ready=1 and evt_id=i.
  - A new edge in the same cycle as its clear keeps pending set. The new event wins and is served later.
- FSM states: IDLE, OFFER.
  - IDLE, pending != 0: scan channels rr_ptr, rr_ptr+1, ... modulo N. Register the first set index into evt_id, go to OFFER, evt_valid=1.
  - IDLE, pending == 0: stay in IDLE, evt_valid=0.
  - OFFER, evt_ready=0: hold. evt_id and evt_valid stay stable; new edges on other channels do not change evt_id.
  - OFFER, evt_ready=1: transfer completes. Clear pending[evt_id], set rr_ptr <= (evt_id==N-1) ? 0 : evt_id+1, go to IDLE, evt_valid=0.
- Latency: sig rises before posedge k. pending is set after posedge k. evt_valid is high after posedge k+1 when the FSM is idle.
- Throughput: at most one event per 2 cycles, because of the mandatory IDLE cycle between grants.
- Fairness: a channel that stays pending is granted within N grants.
- Wrap-around: for N not a power of two, the scan and rr_ptr wrap at N-1 -> 0. Indices >= N are never produced.
- Coalescing: multiple rising edges on one channel while it is pending merge into one event.
- Reset mid-operation: rst in OFFER drops evt_valid the next cycle, discards all pending events and re-seeds sig_dly.
- evt_ready while evt_valid=0 is ignored.

Optional Feature:
- Macro: EDGE_EVT_OVERFLOW_EN.
- Defined:
  - overflow[i] is set when edge[i] & pending[i] & ~clr[i], i.e. an event is lost to coalescing.
  - overflow[i] is cleared by ovf_clr[i]. Set has priority over clear in the same cycle.
  - overflow bits are sticky until cleared or reset.
- Undefined: overflow and ovf_clr ports are absent, and coalescing is silent.

Test Plan:
- Single edge: rst, then sig[2] 0->1 before edge k, evt_ready=1 -> evt_valid=1 and evt_id=2 after edge k+1; pending=0 and evt_valid=0 after edge k+2.
- Round-robin: sig[0], sig[1] and sig[3] rise together, evt_ready=1 -> grants in order 0, 1, 3, one every 2 cycles; then sig[0] and sig[3] rise again -> 0, then 3 (rr_ptr=0 after the grant of 3).
- Backpressure: offer ch1 with evt_ready=0 for 5 cycles while sig[0] rises -> evt_id stays 1 for all 5 cycles; ch0 is granted after ch1 is accepted.
- Same-cycle re-edge: sig[1] falls then rises so that the edge lands in the accept cycle of ch1 -> pending[1] stays 1 and ch1 is offered again.
- Reset: sig=4'b1111 held through rst release -> no events; rst asserted in OFFER -> evt_valid=0 and pending=0 on the next cycle.
- Overflow (macro defined): two rising edges on ch2 while evt_ready=0 -> overflow[2]=1 and one event delivered; ovf_clr[2]=1 -> overflow[2]=0.
